// File: rtl/delivery_sequencer_if.sv
// rtl/delivery_sequencer_if.sv - bowl/score bus between the delivery sequencer and the innings scorer
//
// Purpose: bundles the player controls, the packed team data returned by the
// scorer and the delivery/progress outputs driven back to the scorer.
//
// Signals:
//   bowl_btn      level, rising edge requests a delivery
//   team_sw       score-view toggle, bowl edges ignored while high
//   force_en      select force_code instead of the LFSR outcome
//   force_code    forced outcome (9..15 read as 0)
//   team1_data    {runs[7:0], wickets[3:0]} of team 1
//   team2_data    {runs[7:0], wickets[3:0]} of team 2
//   delivery      one-cycle strobe committing outcome_code
//   outcome_code  committed outcome 0..8
//   balls         legal balls in the current over
//   overs         completed overs in the current innings
//   inning_over   0 = team 1 batting, 1 = team 2 batting
//   game_over     sticky match-complete flag
//   winner        0 = team 1, 1 = team 2 (valid with game_over)
//   free_hit      next delivery is a free hit
//
// Modports: master = sequencer side, slave = scorer/player side.

interface delivery_sequencer_if;
  logic        bowl_btn;
  logic        team_sw;
  logic        force_en;
  logic [3:0]  force_code;
  logic [11:0] team1_data;
  logic [11:0] team2_data;
  logic        delivery;
  logic [3:0]  outcome_code;
  logic [2:0]  balls;
  logic [4:0]  overs;
  logic        inning_over;
  logic        game_over;
  logic        winner;
  logic        free_hit;

  modport master (
    input  bowl_btn, team_sw, force_en, force_code, team1_data, team2_data,
    output delivery, outcome_code, balls, overs, inning_over, game_over,
           winner, free_hit
  );

  modport slave (
    output bowl_btn, team_sw, force_en, force_code, team1_data, team2_data,
    input  delivery, outcome_code, balls, overs, inning_over, game_over,
           winner, free_hit
  );
endinterface

// File: rtl/delivery_sequencer.sv
// rtl/delivery_sequencer.sv - turns the bowl button into delivery strobes and tracks innings progress
//
// Purpose: on a bowl_btn rising edge (team_sw low, match not over) latch an
// outcome code (forced or from an 8-bit LFSR), pulse delivery for one cycle,
// wait two cycles for the scorer to update the team data, then evaluate
// ball/over counters and the innings/match end conditions.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    delivery_sequencer_if.master (controls, team data, outputs)
//
// Parameters: OVERS (1..31), BALLS_PER_OVER (1..7), MAX_WICKETS (1..15),
//             LFSR_SEED (non-zero).
//
// Optional feature: define FREE_HIT_EN to enable free-hit tracking, where
// a wicket (code 8) following a no-ball (code 7) is replaced by a dot ball.
// Without it free_hit is tied low and codes pass through unchanged.

module delivery_sequencer #(
  parameter int         OVERS          = 20,
  parameter int         BALLS_PER_OVER = 6,
  parameter int         MAX_WICKETS    = 10,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  delivery_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] BPO_L   = 3'(BALLS_PER_OVER);
  localparam logic [4:0] OVERS_L = 5'(OVERS);
  localparam logic [3:0] MAXW_L  = 4'(MAX_WICKETS);

  logic [2:0] state_q, state_d;
  logic       settle_q, settle_d;
  logic       btn_q;
  logic [7:0] lfsr_q;
  logic [3:0] code_q, code_d;
  logic       delivery_q, delivery_d;
  logic [2:0] balls_q, balls_d;
  logic [4:0] overs_q, overs_d;
  logic       inning_q, inning_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
`ifdef FREE_HIT_EN
  logic       fh_q, fh_d;
`endif

  logic       bowl_edge;
  logic       lfsr_fb;
  logic [3:0] lfsr_raw;
  logic [3:0] lfsr_code;
  logic [3:0] forced_code;
  logic [3:0] pick_code;
  logic [3:0] new_code;
  logic       legal;
  logic       ball_wrap;
  logic [2:0] balls_next;
  logic [4:0] overs_next;
  logic       overs_done;
  logic [7:0] t1_runs, t2_runs;
  logic [3:0] t1_wk, t2_wk;

  assign bowl_edge = bus.bowl_btn & ~btn_q;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_raw  = lfsr_q[3:0];
  // Fold 9..15 back onto 0..6 so every LFSR value maps to a valid outcome.
  assign lfsr_code = (lfsr_raw <= 4'd8) ? lfsr_raw : lfsr_raw - 4'd9;

  assign forced_code = (bus.force_code <= 4'd8) ? bus.force_code : 4'd0;
  assign pick_code   = bus.force_en ? forced_code : lfsr_code;

`ifdef FREE_HIT_EN
  // A batter cannot be dismissed on a free hit: wicket becomes a dot ball.
  assign new_code = (fh_q && pick_code == 4'd8) ? 4'd0 : pick_code;
`else
  assign new_code = pick_code;
`endif

  // Wides (5) and no-balls (7) do not count towards the over.
  assign legal      = (code_q != 4'd5) && (code_q != 4'd7);
  assign ball_wrap  = (balls_q + 3'd1) == BPO_L;
  assign balls_next = !legal ? balls_q : (ball_wrap ? 3'd0 : balls_q + 3'd1);
  assign overs_next = (legal && ball_wrap) ? overs_q + 5'd1 : overs_q;
  assign overs_done = (overs_next == OVERS_L);

  assign t1_runs = bus.team1_data[11:4];
  assign t1_wk   = bus.team1_data[3:0];
  assign t2_runs = bus.team2_data[11:4];
  assign t2_wk   = bus.team2_data[3:0];

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    code_d      = code_q;
    delivery_d  = 1'b0;
    balls_d     = balls_q;
    overs_d     = overs_q;
    inning_d    = inning_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
`ifdef FREE_HIT_EN
    fh_d        = fh_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bowl_edge && !bus.team_sw && !game_over_q) begin
          code_d  = new_code;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        delivery_d = 1'b1;
        settle_d   = 1'b0;
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        // Two cycles for the scorer to fold the delivery into team data.
        if (settle_q) begin
          state_d = S_EVAL;
        end else begin
          settle_d = 1'b1;
        end
      end
      S_EVAL: begin
        state_d = S_IDLE;
`ifdef FREE_HIT_EN
        fh_d = (code_q == 4'd7);
`endif
        if (!inning_q) begin
          if (t1_wk >= MAXW_L || overs_done) begin
            inning_d = 1'b1;
            balls_d  = 3'd0;
            overs_d  = 5'd0;
          end else begin
            balls_d = balls_next;
            overs_d = overs_next;
          end
        end else begin
          balls_d = balls_next;
          overs_d = overs_next;
          // Chase achieved wins outright, even on the last ball or last wicket.
          if (t2_runs > t1_runs) begin
            game_over_d = 1'b1;
            winner_d    = 1'b1;
            state_d     = S_DONE;
          end else if (t2_wk >= MAXW_L || overs_done) begin
            game_over_d = 1'b1;
            winner_d    = 1'b0;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      settle_q    <= 1'b0;
      btn_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      code_q      <= 4'd0;
      delivery_q  <= 1'b0;
      balls_q     <= 3'd0;
      overs_q     <= 5'd0;
      inning_q    <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      btn_q       <= bus.bowl_btn;
      lfsr_q      <= {lfsr_q[6:0], lfsr_fb};
      code_q      <= code_d;
      delivery_q  <= delivery_d;
      balls_q     <= balls_d;
      overs_q     <= overs_d;
      inning_q    <= inning_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

`ifdef FREE_HIT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fh_q <= 1'b0;
    end else begin
      fh_q <= fh_d;
    end
  end
  assign bus.free_hit = fh_q;
`else
  assign bus.free_hit = 1'b0;
`endif

  assign bus.delivery     = delivery_q;
  assign bus.outcome_code = code_q;
  assign bus.balls        = balls_q;
  assign bus.overs        = overs_q;
  assign bus.inning_over  = inning_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_delivery_sequencer.sv
// tb/tb_delivery_sequencer.sv - self-checking bench for delivery_sequencer

module tb_delivery_sequencer;

  localparam int         OVERS  = 20;
  localparam int         BPO    = 6;
  localparam int         MAXW   = 10;
  localparam logic [7:0] SEED   = 8'hA5;
`ifdef FREE_HIT_EN
  localparam bit         FH_ON  = 1'b1;
`else
  localparam bit         FH_ON  = 1'b0;
`endif

  logic clk;
  logic reset;

  delivery_sequencer_if bus ();

  delivery_sequencer #(
    .OVERS          (OVERS),
    .BALLS_PER_OVER (BPO),
    .MAX_WICKETS    (MAXW),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_lfsr;
  int m_legal, m_inn, m_go, m_win, m_fh;
  int t1r, t1w, t2r, t2w;

  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_teams();
    bus.team1_data = {t1r[7:0], t1w[3:0]};
    bus.team2_data = {t2r[7:0], t2w[3:0]};
  endtask

  function automatic int expect_code(input bit fe, input logic [3:0] fc, input logic [7:0] lf);
    int r;
    if (fe) r = (int'(fc) > 8) ? 0 : int'(fc);
    else begin
      r = int'(lf[3:0]);
      if (r > 8) r = r - 9;
    end
    if (FH_ON && m_fh != 0 && r == 8) r = 0;
    return r;
  endfunction

  // Stub scorer: credits the batting team with the delivery's effect.
  task automatic stub_score(input int c);
    int add;
    case (c)
      1: add = 1; 2: add = 2; 3: add = 3; 4: add = 4;
      5: add = 1; 6: add = 6; 7: add = 1;
      default: add = 0;
    endcase
    if (m_inn == 0) begin
      t1r = (t1r + add) % 256;
      if (c == 8 && t1w < 15) t1w++;
    end else begin
      t2r = (t2r + add) % 256;
      if (c == 8 && t2w < 15) t2w++;
    end
    drive_teams();
  endtask

  task automatic model_eval(input int c);
    if (c != 5 && c != 7) m_legal++;
    if (m_inn == 0) begin
      if (t1w >= MAXW || m_legal == OVERS * BPO) begin
        m_inn   = 1;
        m_legal = 0;
      end
    end else begin
      if (t2r > t1r) begin
        m_go = 1; m_win = 1;
      end else if (t2w >= MAXW || m_legal == OVERS * BPO) begin
        m_go = 1; m_win = 0;
      end
    end
    m_fh = (FH_ON && c == 7) ? 1 : 0;
  endtask

  task automatic chk_state();
    chk("balls", int'(bus.balls), m_legal % BPO);
    chk("overs", int'(bus.overs), m_legal / BPO);
    chk("inning_over", int'(bus.inning_over), m_inn);
    chk("game_over", int'(bus.game_over), m_go);
    chk("winner", int'(bus.winner), m_win);
    chk("free_hit", int'(bus.free_hit), m_fh);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.bowl_btn   = 1'b0;
    bus.team_sw    = 1'b0;
    bus.force_en   = 1'b0;
    bus.force_code = 4'd0;
    m_legal = 0; m_inn = 0; m_go = 0; m_win = 0; m_fh = 0;
    t1r = 0; t1w = 0; t2r = 0; t2w = 0;
    drive_teams();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One press; checks strobe timing, code and post-EVAL state against the model.
  task automatic bowl(input bit fe, input logic [3:0] fc, input bit sw, output int got);
    int ec;
    int seen;
    bit want;
    want = (sw == 1'b0) && (m_go == 0);
    got  = -1;
    @(negedge clk);
    ec = expect_code(fe, fc, m_lfsr);
    bus.force_en   = fe;
    bus.force_code = fc;
    bus.team_sw    = sw;
    bus.bowl_btn   = 1'b1;
    if (want) begin
      @(posedge clk); #1;
      chk("dly_early", int'(bus.delivery), 0);
      @(posedge clk); #1;
      chk("dly_strobe", int'(bus.delivery), 1);
      chk("outcome_code", int'(bus.outcome_code), ec);
      got = int'(bus.outcome_code);
      @(negedge clk);
      bus.bowl_btn = 1'b0;
      bus.team_sw  = 1'b0;
      stub_score(ec);
      @(posedge clk); #1;
      chk("dly_one_cycle", int'(bus.delivery), 0);
      @(posedge clk);
      @(posedge clk); #1;
      model_eval(ec);
    end else begin
      seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (bus.delivery) seen++;
      end
      chk("no_delivery", seen, 0);
      @(negedge clk);
      bus.bowl_btn = 1'b0;
      bus.team_sw  = 1'b0;
      @(posedge clk); #1;
    end
    chk_state();
  endtask

  typedef struct {
    bit         fe;
    logic [3:0] fc;
    int         code;
    int         balls;
    int         overs;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   c, c2, seen, i;

    tbl[0]  = '{1'b1, 4'd4,  4, 1, 0};
    tbl[1]  = '{1'b1, 4'd1,  1, 2, 0};
    tbl[2]  = '{1'b1, 4'd1,  1, 3, 0};
    tbl[3]  = '{1'b1, 4'd1,  1, 4, 0};
    tbl[4]  = '{1'b1, 4'd1,  1, 5, 0};
    tbl[5]  = '{1'b1, 4'd1,  1, 0, 1};
    tbl[6]  = '{1'b1, 4'd5,  5, 0, 1};
    tbl[7]  = '{1'b1, 4'd7,  7, 0, 1};
    tbl[8]  = '{1'b1, 4'd9,  0, 1, 1};
    tbl[9]  = '{1'b1, 4'd15, 0, 2, 1};
    tbl[10] = '{1'b1, 4'd8,  8, 3, 1};

    reset = 1'b1;
    bus.bowl_btn = 1'b0; bus.team_sw = 1'b0; bus.force_en = 1'b0; bus.force_code = 4'd0;
    bus.team1_data = 12'd0; bus.team2_data = 12'd0;
    do_reset();

    // Reset values
    chk("rst_delivery", int'(bus.delivery), 0);
    chk("rst_code", int'(bus.outcome_code), 0);
    chk_state();

    // Table: single deliveries, over wrap, wide/no-ball, code folding
    for (int k = 0; k < 11; k++) begin
      bowl(tbl[k].fe, tbl[k].fc, 1'b0, c);
      chk("tbl_code", c, tbl[k].code);
      chk("tbl_balls", int'(bus.balls), tbl[k].balls);
      chk("tbl_overs", int'(bus.overs), tbl[k].overs);
    end

    // Ten wickets end innings 1
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bowl(1'b1, 4'd8, 1'b0, c);
      if (k == 8) chk("inn1_not_yet", int'(bus.inning_over), 0);
    end
    chk("inn1_over", int'(bus.inning_over), 1);
    chk("inn1_balls", int'(bus.balls), 0);
    chk("inn1_overs", int'(bus.overs), 0);

    // Chase: team2 passes 50 on the next single
    @(negedge clk);
    t1r = 50; t1w = 3; t2r = 50; t2w = 0;
    drive_teams();
    bowl(1'b1, 4'd1, 1'b0, c);
    chk("chase_game_over", int'(bus.game_over), 1);
    chk("chase_winner", int'(bus.winner), 1);
    bowl(1'b1, 4'd4, 1'b0, c);
    chk("done_winner_held", int'(bus.winner), 1);

    // team_sw blocks the press; second press during SETTLE is dropped
    do_reset();
    bowl(1'b1, 4'd2, 1'b1, c);
    @(negedge clk);
    bus.force_en = 1'b1; bus.force_code = 4'd3; bus.bowl_btn = 1'b1;
    seen = 0;
    for (i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.delivery) seen++;
      @(negedge clk);
      if (i == 2) bus.bowl_btn = 1'b0;
      if (i == 3) bus.bowl_btn = 1'b1;
    end
    bus.bowl_btn = 1'b0;
    model_eval(3);
    chk("settle_press_dropped", seen, 1);
    chk("settle_code", int'(bus.outcome_code), 3);
    @(posedge clk); #1;
    chk_state();

    // Reset during LAUNCH
    @(negedge clk);
    bus.force_code = 4'd2; bus.bowl_btn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_launch_delivery", int'(bus.delivery), 0);
    chk("rst_launch_balls", int'(bus.balls), 0);
    chk("rst_launch_code", int'(bus.outcome_code), 0);
    @(negedge clk);
    reset = 1'b0; bus.bowl_btn = 1'b0;
    m_legal = 0; m_inn = 0; m_go = 0; m_win = 0; m_fh = 0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.delivery) seen++;
    end
    chk("rst_launch_no_strobe", seen, 0);

    // Free hit: no-ball then wicket
    do_reset();
    bowl(1'b1, 4'd7, 1'b0, c);
    chk("fh_after_noball", int'(bus.free_hit), FH_ON ? 1 : 0);
    bowl(1'b1, 4'd8, 1'b0, c2);
    chk("fh_wicket_code", c2, FH_ON ? 0 : 8);
    chk("fh_cleared", int'(bus.free_hit), 0);

    // Randomized presses against the model
    do_reset();
    for (int k = 0; k < 200; k++) begin
      bit         fe;
      logic [3:0] fc;
      bit         sw;
      fe = ($urandom % 4) != 0;
      fc = (($urandom % 3) == 0) ? 4'd8 : 4'($urandom % 16);
      sw = ($urandom % 10) == 0;
      bowl(fe, fc, sw, c);
      if (m_go != 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
